// File: rtl/tof_focal_sequencer.sv
// -----------------------------------------------------------------------------
// tof_focal_sequencer
//
// Purpose:
//   Feeds the focal-point accumulation stage. Pops transducer A and B echo
//   samples from their FIFOs in lockstep and counts the sample index. It looks
//   up each sample's time-of-flight focal-point index in two runtime-loaded
//   LUTs (one per transducer). It then presents {sample, focal point} pairs
//   with a valid strobe. One acquisition of N_SAMPLES runs per start pulse.
//
// Ports:
//   Clk, reset                 clock (rising edge), async active-high reset
//   start, abort               acquisition control
//   fifo_A_data, fifo_B_data   FIFO read data, valid the cycle after a pop
//   fifo_empty_A, fifo_empty_B FIFO empty flags
//   lut_wr_en/sel/addr/data    LUT load port (IDLE only; sel 0 = A, 1 = B)
//   rd_en_A, rd_en_B           FIFO pops (combinational, always equal)
//   sample_A/B, focal_A/B      output pair, qualified by out_valid
//   out_valid, busy, done      status strobes
//   sample_count               samples popped in current/last acquisition
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; LUT writes accepted
// RUN    | popping both FIFOs whenever both are non-empty
// FLUSH  | last sample being presented; done follows in IDLE
// -----------------------------------------------------------------------------
module tof_focal_sequencer #(
    parameter int WIDTH     = 3,
    parameter int PTR_LEN   = 4,
    parameter int N_SAMPLES = 16,
    parameter int SAMP_LEN  = 4
) (
    input  logic                Clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [WIDTH-1:0]    fifo_A_data,
    input  logic [WIDTH-1:0]    fifo_B_data,
    input  logic                fifo_empty_A,
    input  logic                fifo_empty_B,
    input  logic                lut_wr_en,
    input  logic                lut_wr_sel,
    input  logic [SAMP_LEN-1:0] lut_wr_addr,
    input  logic [PTR_LEN-1:0]  lut_wr_data,
    output logic                rd_en_A,
    output logic                rd_en_B,
    output logic [WIDTH-1:0]    sample_A,
    output logic [WIDTH-1:0]    sample_B,
    output logic [PTR_LEN-1:0]  focal_A,
    output logic [PTR_LEN-1:0]  focal_B,
    output logic                out_valid,
    output logic                busy,
    output logic                done,
    output logic [SAMP_LEN-1:0] sample_count
);

    localparam int DEPTH = 2 ** SAMP_LEN;
    // The count must be able to reach N_SAMPLES itself, hence one extra bit.
    localparam logic [SAMP_LEN:0] C_N_SAMPLES = (SAMP_LEN + 1)'(N_SAMPLES);
    localparam logic [SAMP_LEN:0] C_ONE       = (SAMP_LEN + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    logic [SAMP_LEN:0]   r_count;
    logic                r_valid;
    logic                r_done;
    logic                r_busy;
    logic [WIDTH-1:0]    r_hold_a;
    logic [WIDTH-1:0]    r_hold_b;
    logic [PTR_LEN-1:0]  r_focal_a;
    logic [PTR_LEN-1:0]  r_focal_b;
    logic [PTR_LEN-1:0]  r_lut_a [DEPTH];
    logic [PTR_LEN-1:0]  r_lut_b [DEPTH];

    logic                w_pop;
    logic                w_lut_we;
    logic [SAMP_LEN:0]   w_count_nxt;
    logic [SAMP_LEN-1:0] w_idx;

    // Both FIFOs pop together or not at all; abort suppresses the pop.
    assign w_pop       = (r_state == ST_RUN) & ~fifo_empty_A & ~fifo_empty_B & ~abort;
    assign w_lut_we    = lut_wr_en & (r_state == ST_IDLE);
    assign w_count_nxt = r_count + C_ONE;
    assign w_idx       = r_count[SAMP_LEN-1:0];

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_hold_a  <= '0;
            r_hold_b  <= '0;
            r_focal_a <= '0;
            r_focal_b <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_lut_a[i] <= '0;
                r_lut_b[i] <= '0;
            end
        end else begin
            r_valid <= w_pop;
            r_done  <= 1'b0;

            // FIFO data is only present during the valid cycle; keep a copy
            // so the outputs hold afterwards.
            if (r_valid) begin
                r_hold_a <= fifo_A_data;
                r_hold_b <= fifo_B_data;
            end

            if (w_pop) begin
                r_count   <= w_count_nxt;
                r_focal_a <= r_lut_a[w_idx];
                r_focal_b <= r_lut_b[w_idx];
            end

            if (w_lut_we) begin
                if (lut_wr_sel) begin
                    r_lut_b[lut_wr_addr] <= lut_wr_data;
                end else begin
                    r_lut_a[lut_wr_addr] <= lut_wr_data;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (!abort && start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_count <= '0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_pop && (w_count_nxt == C_N_SAMPLES)) begin
                        r_state <= ST_FLUSH;
                        r_busy  <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_IDLE;
                    r_done  <= ~abort;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_en_A      = w_pop;
    assign rd_en_B      = w_pop;
    assign sample_A     = r_valid ? fifo_A_data : r_hold_a;
    assign sample_B     = r_valid ? fifo_B_data : r_hold_b;
    assign focal_A      = r_focal_a;
    assign focal_B      = r_focal_b;
    assign out_valid    = r_valid;
    assign busy         = r_busy;
    assign done         = r_done;
    assign sample_count = r_count[SAMP_LEN-1:0];

endmodule

// File: tb/tb_tof_focal_sequencer.sv
module tb_tof_focal_sequencer;

    localparam int WIDTH     = 3;
    localparam int PTR_LEN   = 4;
    localparam int N_SAMPLES = 16;
    localparam int SAMP_LEN  = 4;
    localparam int DEPTH     = 2 ** SAMP_LEN;

    logic                Clk = 1'b0;
    logic                reset;
    logic                start;
    logic                abort;
    logic [WIDTH-1:0]    fifo_A_data;
    logic [WIDTH-1:0]    fifo_B_data;
    logic                fifo_empty_A;
    logic                fifo_empty_B;
    logic                lut_wr_en;
    logic                lut_wr_sel;
    logic [SAMP_LEN-1:0] lut_wr_addr;
    logic [PTR_LEN-1:0]  lut_wr_data;
    logic                rd_en_A;
    logic                rd_en_B;
    logic [WIDTH-1:0]    sample_A;
    logic [WIDTH-1:0]    sample_B;
    logic [PTR_LEN-1:0]  focal_A;
    logic [PTR_LEN-1:0]  focal_B;
    logic                out_valid;
    logic                busy;
    logic                done;
    logic [SAMP_LEN-1:0] sample_count;

    tof_focal_sequencer #(
        .WIDTH(WIDTH), .PTR_LEN(PTR_LEN), .N_SAMPLES(N_SAMPLES), .SAMP_LEN(SAMP_LEN)
    ) dut (
        .Clk(Clk), .reset(reset), .start(start), .abort(abort),
        .fifo_A_data(fifo_A_data), .fifo_B_data(fifo_B_data),
        .fifo_empty_A(fifo_empty_A), .fifo_empty_B(fifo_empty_B),
        .lut_wr_en(lut_wr_en), .lut_wr_sel(lut_wr_sel),
        .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data),
        .rd_en_A(rd_en_A), .rd_en_B(rd_en_B),
        .sample_A(sample_A), .sample_B(sample_B),
        .focal_A(focal_A), .focal_B(focal_B),
        .out_valid(out_valid), .busy(busy), .done(done),
        .sample_count(sample_count)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Environment: FIFO contents, expected sample streams, LUT model.
    logic [WIDTH-1:0]   fa[$], fb[$], ea[$], eb[$];
    logic [PTR_LEN-1:0] lut_a_m [DEPTH];
    logic [PTR_LEN-1:0] lut_b_m [DEPTH];
    logic [PTR_LEN-1:0] rec_fa [N_SAMPLES];
    logic [PTR_LEN-1:0] rec_fb [N_SAMPLES];
    bit  mon_en, pop_pending, hold_a, hold_b;
    int  cyc, n_valid, n_pop, n_done, done_cyc, last_valid_cyc;
    logic [WIDTH-1:0]   last_sa, last_sb;
    logic [PTR_LEN-1:0] last_fa, last_fb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd_flags();
        fifo_empty_A = (fa.size() == 0) || hold_a;
        fifo_empty_B = (fb.size() == 0) || hold_b;
    endtask

    // FIFO model: read data appears shortly after the edge that performed the pop.
    always begin
        @(posedge Clk);
        #1;
        if (pop_pending && !reset && fa.size() > 0 && fb.size() > 0) begin
            fifo_A_data = fa.pop_front();
            fifo_B_data = fb.pop_front();
        end
        upd_flags();
    end

    // Monitor: the k-th valid of a run must carry the k-th pushed samples and LUT[k].
    always @(negedge Clk) begin
        logic [WIDTH-1:0] xa, xb;
        cyc++;
        pop_pending = rd_en_A;
        if (mon_en) begin
            chk("rd_en_lockstep", 32'(rd_en_B), 32'(rd_en_A));
            if (rd_en_A) begin
                n_pop++;
                chk("pop_while_empty", 32'(fifo_empty_A | fifo_empty_B), 32'(0));
            end
            if (out_valid) begin
                if (ea.size() == 0 || n_valid >= N_SAMPLES) begin
                    chk("valid_unexpected", 32'(out_valid), 32'(0));
                end else begin
                    xa = ea.pop_front();
                    xb = eb.pop_front();
                    chk("sample_A", 32'(sample_A), 32'(xa));
                    chk("sample_B", 32'(sample_B), 32'(xb));
                    chk("focal_A",  32'(focal_A),  32'(lut_a_m[n_valid]));
                    chk("focal_B",  32'(focal_B),  32'(lut_b_m[n_valid]));
                    rec_fa[n_valid] = focal_A;
                    rec_fb[n_valid] = focal_B;
                end
                last_sa = sample_A; last_sb = sample_B;
                last_fa = focal_A;  last_fb = focal_B;
                n_valid++;
                last_valid_cyc = cyc;
            end else begin
                chk("hold_sample_A", 32'(sample_A), 32'(last_sa));
                chk("hold_sample_B", 32'(sample_B), 32'(last_sb));
                chk("hold_focal_A",  32'(focal_A),  32'(last_fa));
                chk("hold_focal_B",  32'(focal_B),  32'(last_fb));
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic clear_env();
        fa.delete(); fb.delete(); ea.delete(); eb.delete();
        n_valid = 0; n_pop = 0; n_done = 0;
        hold_a = 1'b0; hold_b = 1'b0;
        upd_flags();
    endtask

    // mode 0: A = i%8, B = 7; mode 1: random
    task automatic load_run(input int mode);
        logic [WIDTH-1:0] a, b;
        for (int i = 0; i < N_SAMPLES; i++) begin
            a = (mode == 0) ? WIDTH'(i % 8) : WIDTH'($urandom_range(0, 7));
            b = (mode == 0) ? WIDTH'(7)     : WIDTH'($urandom_range(0, 7));
            fa.push_back(a); fb.push_back(b);
            ea.push_back(a); eb.push_back(b);
        end
        upd_flags();
    endtask

    task automatic lut_write(input logic sel, input int addr, input int data, input bit model);
        lut_wr_en   = 1'b1;
        lut_wr_sel  = sel;
        lut_wr_addr = SAMP_LEN'(addr);
        lut_wr_data = PTR_LEN'(data);
        tick();
        lut_wr_en = 1'b0;
        if (model) begin
            if (sel) lut_b_m[addr] = PTR_LEN'(data);
            else     lut_a_m[addr] = PTR_LEN'(data);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (n_done != 0) break;
            tick();
        end
        chk(tag, 32'(n_done != 0), 32'(1));
        tick();
        tick();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"},   32'(out_valid),    32'(0));
        chk({tag, "_busy"},    32'(busy),         32'(0));
        chk({tag, "_done"},    32'(done),         32'(0));
        chk({tag, "_rd_en_A"}, 32'(rd_en_A),      32'(0));
        chk({tag, "_rd_en_B"}, 32'(rd_en_B),      32'(0));
        chk({tag, "_sampleA"}, 32'(sample_A),     32'(0));
        chk({tag, "_sampleB"}, 32'(sample_B),     32'(0));
        chk({tag, "_focalA"},  32'(focal_A),      32'(0));
        chk({tag, "_focalB"},  32'(focal_B),      32'(0));
        chk({tag, "_count"},   32'(sample_count), 32'(0));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        fifo_A_data = '0; fifo_B_data = '0;
        lut_wr_en = 1'b0; lut_wr_sel = 1'b0; lut_wr_addr = '0; lut_wr_data = '0;
        mon_en = 1'b0; pop_pending = 1'b0; hold_a = 1'b0; hold_b = 1'b0;
        last_sa = '0; last_sb = '0; last_fa = '0; last_fb = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lut_a_m[i] = '0; lut_b_m[i] = '0;
        end
        upd_flags();
        #12;
        chk_zero_outputs("reset");
        tick();
        reset = 1'b0;
        mon_en = 1'b1;

        // T1: ramp LUTs, A = i%8, B = 7
        for (int i = 0; i < DEPTH; i++) begin
            lut_write(1'b0, i, i, 1'b1);
            lut_write(1'b1, i, 15 - i, 1'b1);
        end
        clear_env();
        load_run(0);
        pulse_start();
        @(negedge Clk);
        chk("t1_busy_in_run", 32'(busy), 32'(1));
        wait_done("t1_done_seen", 200);
        chk("t1_valids",   32'(n_valid), 32'(N_SAMPLES));
        chk("t1_done_lat", 32'(done_cyc - last_valid_cyc), 32'(1));
        chk("t1_done_once", 32'(n_done), 32'(1));
        chk("t1_busy_end", 32'(busy), 32'(0));

        // T2: B starved for 5 cycles mid-run
        clear_env();
        load_run(1);
        pulse_start();
        tick(); tick(); tick();
        hold_b = 1'b1;
        upd_flags();
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("t2_stall_rd_en_A", 32'(rd_en_A), 32'(0));
            chk("t2_stall_busy", 32'(busy), 32'(1));
            if (i > 0) chk("t2_stall_valid", 32'(out_valid), 32'(0));
            tick();
        end
        hold_b = 1'b0;
        upd_flags();
        wait_done("t2_done_seen", 200);
        chk("t2_valids", 32'(n_valid), 32'(N_SAMPLES));

        // T3: abort after 6 pops
        clear_env();
        load_run(1);
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            if (n_pop >= 6) break;
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge Clk);
        chk("t3_idle_busy", 32'(busy), 32'(0));
        chk("t3_count", 32'(sample_count), 32'(6));
        chk("t3_rd_en", 32'(rd_en_A), 32'(0));
        tick(); tick(); tick();
        chk("t3_no_done", 32'(n_done), 32'(0));
        chk("t3_pops", 32'(n_pop), 32'(6));
        chk("t3_valids", 32'(n_valid), 32'(6));

        // T4: LUT write during RUN ignored, in IDLE (with start) honoured
        clear_env();
        load_run(1);
        pulse_start();
        tick(); tick();
        lut_wr_en = 1'b1; lut_wr_sel = 1'b0; lut_wr_addr = 4'd3; lut_wr_data = 4'd9;
        tick();
        lut_wr_en = 1'b0;
        wait_done("t4a_done_seen", 200);
        chk("t4_run_write_ignored", 32'(rec_fa[3]), 32'(3));
        clear_env();
        load_run(1);
        lut_wr_en = 1'b1; lut_wr_sel = 1'b0; lut_wr_addr = 4'd3; lut_wr_data = 4'd9;
        start = 1'b1;
        lut_a_m[3] = 4'd9;
        tick();
        lut_wr_en = 1'b0;
        start = 1'b0;
        wait_done("t4b_done_seen", 200);
        chk("t4_idle_write_taken", 32'(rec_fa[3]), 32'(9));
        chk("t4_valids", 32'(n_valid), 32'(N_SAMPLES));

        // T5: asynchronous reset mid-run
        clear_env();
        load_run(1);
        pulse_start();
        tick(); tick(); tick(); tick(); tick();
        @(negedge Clk);
        #1;
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        chk_zero_outputs("t5_async");
        for (int i = 0; i < DEPTH; i++) begin
            lut_a_m[i] = '0; lut_b_m[i] = '0;
        end
        clear_env();
        last_sa = '0; last_sb = '0; last_fa = '0; last_fb = '0;
        tick(); tick();
        reset = 1'b0;
        mon_en = 1'b1;
        load_run(1);
        pulse_start();
        wait_done("t5_done_seen", 200);
        chk("t5_focalA_cleared", 32'(rec_fa[5]), 32'(0));
        chk("t5_focalB_cleared", 32'(rec_fb[5]), 32'(0));
        chk("t5_valids", 32'(n_valid), 32'(N_SAMPLES));

        // T6: random LUTs, start pulses while busy, toggling empties
        for (int i = 0; i < DEPTH; i++) begin
            lut_write(1'b0, i, int'($urandom_range(0, 15)), 1'b1);
            lut_write(1'b1, i, int'($urandom_range(0, 15)), 1'b1);
        end
        clear_env();
        load_run(1);
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            if (n_done != 0) break;
            hold_a = ~hold_a;
            hold_b = ($urandom_range(0, 3) == 0);
            start  = busy && ($urandom_range(0, 1) == 1);
            upd_flags();
            tick();
        end
        start = 1'b0;
        hold_a = 1'b0;
        hold_b = 1'b0;
        upd_flags();
        wait_done("t6_done_seen", 50);
        chk("t6_valids", 32'(n_valid), 32'(N_SAMPLES));
        chk("t6_done_once", 32'(n_done), 32'(1));
        chk("t6_busy_end", 32'(busy), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
